// File: rtl/multimode_ff_pkg.sv
// Shared definitions for the multimode flip-flop bank.
// Holds the mode encoding and the single-bit next-state function.
package multimode_ff_pkg;

  typedef enum logic [1:0] {FF_SR, FF_JK, FF_D, FF_T} ff_mode_e;

  // The SR a=b=1 case holds here; flagging it is the caller's job.
  function automatic logic ff_next(ff_mode_e mode, logic q, logic a, logic b);
    logic nxt;
    nxt = q;
    case (mode)
      FF_SR: begin
        if (a && !b)      nxt = 1'b1;
        else if (!a && b) nxt = 1'b0;
        else              nxt = q;
      end
      FF_JK: begin
        case ({a, b})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      FF_D:    nxt = a;
      FF_T:    nxt = a ? ~q : q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One storage channel of the bank: a mode-selectable flip-flop.
// illegal_bit is combinational; the top registers the reduced flag.
module ff_cell
  import multimode_ff_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  ff_mode_e mode,
  input  logic     a,
  input  logic     b,
  output logic     q,
  output logic     illegal_bit
);

  assign illegal_bit = en && (mode == FF_SR) && a && b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= 1'b0;
    else if (en) q <= ff_next(mode, q, a, b);
  end

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH configurable flip-flops with forbidden-SR detection,
// a sticky per-bit mask and a saturating event counter.
module multimode_ff_bank
  import multimode_ff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             illegal,
  output logic [WIDTH-1:0] illegal_mask,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ff_mode_e         mode_e;
  logic [WIDTH-1:0] ill_vec;
  logic             ill_any;

  assign mode_e  = ff_mode_e'(mode);
  assign ill_any = |ill_vec;
  assign qn      = ~q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode_e),
      .a           (a[i]),
      .b           (b[i]),
      .q           (q[i]),
      .illegal_bit (ill_vec[i])
    );
  end

  // A clear on an illegal edge restarts the record with that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal      <= 1'b0;
      illegal_mask <= '0;
      illegal_cnt  <= '0;
    end else begin
      illegal <= ill_any;
      if (clr_sticky) begin
        illegal_mask <= ill_vec;
        illegal_cnt  <= ill_any ? CNT_ONE : '0;
      end else if (ill_any) begin
        illegal_mask <= illegal_mask | ill_vec;
        if (illegal_cnt != CNT_MAX) illegal_cnt <= illegal_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed bench for multimode_ff_bank: an 8-bit counter instance and a
// 2-bit counter instance share stimulus so saturation shows up quickly.
module tb_multimode_ff_bank;
  import multimode_ff_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic       clr_sticky;

  logic [7:0] q8, qn8, mask8;
  logic       ill8;
  logic [7:0] cnt8;
  logic [7:0] q2, qn2, mask2;
  logic       ill2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multimode_ff_bank #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .clr_sticky(clr_sticky), .q(q8), .qn(qn8), .illegal(ill8),
    .illegal_mask(mask8), .illegal_cnt(cnt8)
  );

  multimode_ff_bank #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .clr_sticky(clr_sticky), .q(q2), .qn(qn2), .illegal(ill2),
    .illegal_mask(mask2), .illegal_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input ff_mode_e m, input logic [7:0] av, input logic [7:0] bv,
                      input logic e, input logic clr);
    @(negedge clk);
    mode = m; a = av; b = bv; en = e; clr_sticky = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = FF_SR; a = '0; b = '0; clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q8, 8'h00);
    chk("rst_qn", qn8, 8'hFF);
    chk("rst_ill", ill8, 1'b0);
    chk("rst_mask", mask8, 8'h00);
    chk("rst_cnt", cnt8, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    step(FF_SR, 8'h0F, 8'h00, 1'b1, 1'b0);
    chk("sr_set_q", q8, 8'h0F);
    chk("sr_set_qn", qn8, 8'hF0);
    step(FF_SR, 8'h00, 8'h03, 1'b1, 1'b0);
    chk("sr_reset_q", q8, 8'h0C);
    step(FF_SR, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("sr_hold_q", q8, 8'h0C);

    step(FF_SR, 8'h81, 8'h81, 1'b1, 1'b0);
    chk("sr_ill_q", q8, 8'h0C);
    chk("sr_ill_flag", ill8, 1'b1);
    chk("sr_ill_mask", mask8, 8'h81);
    chk("sr_ill_cnt", cnt8, 8'd1);
    chk("sr_ill_cnt2", cnt2, 2'd1);
    step(FF_SR, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("ill_pulse_end", ill8, 1'b0);
    chk("mask_persist", mask8, 8'h81);
    chk("cnt_persist", cnt8, 8'd1);

    step(FF_JK, 8'hFF, 8'hFF, 1'b1, 1'b0);
    chk("jk_toggle_q", q8, 8'hF3);
    chk("jk_no_ill", ill8, 1'b0);
    chk("jk_cnt", cnt8, 8'd1);
    step(FF_T, 8'h01, 8'h00, 1'b1, 1'b0);
    chk("t_q", q8, 8'hF2);
    step(FF_D, 8'h5A, 8'hFF, 1'b1, 1'b0);
    chk("d_q", q8, 8'h5A);

    step(FF_D, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("en0_d_q", q8, 8'h5A);
    for (int i = 0; i < 2; i++) begin
      step(FF_SR, 8'hFF, 8'hFF, 1'b0, 1'b0);
      chk("en0_sr_q", q8, 8'h5A);
      chk("en0_sr_ill", ill8, 1'b0);
      chk("en0_sr_cnt", cnt8, 8'd1);
      chk("en0_sr_mask", mask8, 8'h81);
    end

    for (int i = 0; i < 5; i++) begin
      step(FF_SR, 8'h03, 8'h03, 1'b1, 1'b0);
      chk("sat_ill", ill2, 1'b1);
    end
    chk("sat_cnt2", cnt2, 2'd3);
    chk("sat_cnt8", cnt8, 8'd6);
    chk("sat_mask8", mask8, 8'h83);
    chk("sat_q", q8, 8'h5A);

    step(FF_SR, 8'h10, 8'h10, 1'b1, 1'b1);
    chk("clr_ill_cnt2", cnt2, 2'd1);
    chk("clr_ill_mask2", mask2, 8'h10);
    chk("clr_ill_cnt8", cnt8, 8'd1);
    chk("clr_ill_flag", ill8, 1'b1);
    step(FF_SR, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("clr_cnt2", cnt2, 2'd0);
    chk("clr_mask2", mask2, 8'h00);
    chk("clr_cnt8", cnt8, 8'd0);
    chk("clr_flag", ill8, 1'b0);
    step(FF_SR, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("pre_arst_q", q8, 8'h5A);

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_q", q8, 8'h00);
    chk("arst_qn", qn8, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    step(FF_D, 8'h3C, 8'h00, 1'b1, 1'b0);
    chk("post_rst_q", q8, 8'h3C);
    chk("post_rst_qn", qn8, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
